// File: rtl/regfile_wb_arbiter.sv
// Register-file writeback arbiter.
// Merges ALU and load-unit writeback requests onto a single register-file
// write port using round-robin arbitration, and keeps a per-register
// scoreboard of writes that have been issued but not yet written back.
module regfile_wb_arbiter #(
  parameter int BITSIZE = 32,
  parameter int REGSIZE = 32
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       alu_valid,
  input  logic [$clog2(REGSIZE)-1:0] alu_rd,
  input  logic [BITSIZE-1:0]         alu_data,
  output logic                       alu_ready,
  input  logic                       lsu_valid,
  input  logic [$clog2(REGSIZE)-1:0] lsu_rd,
  input  logic [BITSIZE-1:0]         lsu_data,
  output logic                       lsu_ready,
  input  logic                       issue_valid,
  input  logic [$clog2(REGSIZE)-1:0] issue_rd,
  output logic                       WriteEnable,
  output logic [$clog2(REGSIZE)-1:0] WriteSelect,
  output logic [BITSIZE-1:0]         WriteData,
  output logic [REGSIZE-1:0]         busy
);

  localparam int SelW = $clog2(REGSIZE);

  // Which requester won the most recent transfer; the other one wins the
  // next contested cycle.
  typedef enum logic {
    GrantAlu = 1'b0,
    GrantLsu = 1'b1
  } grant_e;

  grant_e              lastGrant_q, lastGrant_d;
  logic                wrEn_q, wrEn_d;
  logic [SelW-1:0]     wrSel_q, wrSel_d;
  logic [BITSIZE-1:0]  wrData_q, wrData_d;
  logic [REGSIZE-1:0]  busy_q, busy_d;
  logic                aluGrant;
  logic                lsuGrant;

  // Grant decision: a lone requester wins outright, a contested cycle goes
  // to whoever did not win last; nothing is granted while in reset.
  always_comb begin
    aluGrant = 1'b0;
    lsuGrant = 1'b0;
    if (!rst) begin
      if (alu_valid && (!lsu_valid || (lastGrant_q == GrantLsu))) begin
        aluGrant = 1'b1;
      end else if (lsu_valid) begin
        lsuGrant = 1'b1;
      end
    end
  end

  assign alu_ready = aluGrant;
  assign lsu_ready = lsuGrant;

  // The registered write is masked while reset is high so a write captured
  // just before reset never reaches the register file.
  assign WriteEnable = wrEn_q & ~rst;
  assign WriteSelect = wrSel_q;
  assign WriteData   = wrData_q;
  assign busy        = busy_q;

  // Next-state for the write stage, the round-robin pointer and the
  // scoreboard; a write to r0 is accepted but never enables the port.
  always_comb begin
    lastGrant_d = lastGrant_q;
    wrEn_d      = 1'b0;
    wrSel_d     = wrSel_q;
    wrData_d    = wrData_q;
    busy_d      = busy_q;

    if (aluGrant) begin
      lastGrant_d = GrantAlu;
      wrEn_d      = (alu_rd != '0);
      wrSel_d     = alu_rd;
      wrData_d    = alu_data;
    end else if (lsuGrant) begin
      lastGrant_d = GrantLsu;
      wrEn_d      = (lsu_rd != '0);
      wrSel_d     = lsu_rd;
      wrData_d    = lsu_data;
    end

    // Clear first, then set, so an issue to the register being written
    // this cycle leaves it busy.
    if (WriteEnable) begin
      busy_d[wrSel_q] = 1'b0;
    end
    if (issue_valid && (issue_rd != '0)) begin
      busy_d[issue_rd] = 1'b1;
    end
    busy_d[0] = 1'b0;
  end

  // State registers with synchronous reset; after reset the ALU wins the
  // first contested cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      lastGrant_q <= GrantLsu;
      wrEn_q      <= 1'b0;
      wrSel_q     <= '0;
      wrData_q    <= '0;
      busy_q      <= '0;
    end else begin
      lastGrant_q <= lastGrant_d;
      wrEn_q      <= wrEn_d;
      wrSel_q     <= wrSel_d;
      wrData_q    <= wrData_d;
      busy_q      <= busy_d;
    end
  end

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Directed testbench for regfile_wb_arbiter.
// Inputs change 1ns after a rising edge; the combinational readies and the
// reset-masked WriteEnable are sampled on the falling edge, registered
// outputs 1ns after the next rising edge.
module tb_regfile_wb_arbiter;

  localparam int BITSIZE = 32;
  localparam int REGSIZE = 32;

  logic                clk;
  logic                rst;
  logic                alu_valid;
  logic [4:0]          alu_rd;
  logic [BITSIZE-1:0]  alu_data;
  logic                alu_ready;
  logic                lsu_valid;
  logic [4:0]          lsu_rd;
  logic [BITSIZE-1:0]  lsu_data;
  logic                lsu_ready;
  logic                issue_valid;
  logic [4:0]          issue_rd;
  logic                WriteEnable;
  logic [4:0]          WriteSelect;
  logic [BITSIZE-1:0]  WriteData;
  logic [REGSIZE-1:0]  busy;

  int compared   = 0;
  int mismatched = 0;

  regfile_wb_arbiter #(
    .BITSIZE(BITSIZE),
    .REGSIZE(REGSIZE)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .alu_valid  (alu_valid),
    .alu_rd     (alu_rd),
    .alu_data   (alu_data),
    .alu_ready  (alu_ready),
    .lsu_valid  (lsu_valid),
    .lsu_rd     (lsu_rd),
    .lsu_data   (lsu_data),
    .lsu_ready  (lsu_ready),
    .issue_valid(issue_valid),
    .issue_rd   (issue_rd),
    .WriteEnable(WriteEnable),
    .WriteSelect(WriteSelect),
    .WriteData  (WriteData),
    .busy       (busy)
  );

  // 10ns clock.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Watchdog so the run always ends.
  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout, wanted completion");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [63:0] observed,
                             input logic [63:0] expected);
    compared++;
    if (observed !== expected) begin
      mismatched++;
      $display("[TB] FAIL %s: got 0x%0h, wanted 0x%0h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic r,
                               input logic av, input logic [4:0] ard, input logic [31:0] ad,
                               input logic lv, input logic [4:0] lrd, input logic [31:0] ld,
                               input logic iv, input logic [4:0] ird);
    rst         = r;
    alu_valid   = av;
    alu_rd      = ard;
    alu_data    = ad;
    lsu_valid   = lv;
    lsu_rd      = lrd;
    lsu_data    = ld;
    issue_valid = iv;
    issue_rd    = ird;
  endtask

  task automatic idle(input logic r);
    applyStimulus(r, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0);
  endtask

  task automatic stepClock();
    @(posedge clk);
    #1;
  endtask

  task automatic midCycle();
    @(negedge clk);
  endtask

  initial begin
    idle(1'b1);
    stepClock();
    stepClock();

    // Reset state.
    checkOutput("rst_we", 64'(WriteEnable), 64'd0);
    checkOutput("rst_ws", 64'(WriteSelect), 64'd0);
    checkOutput("rst_wd", 64'(WriteData), 64'd0);
    checkOutput("rst_busy", 64'(busy), 64'd0);

    // Readies stay low while reset is held even with requests present.
    applyStimulus(1'b1, 1'b1, 5'd3, 32'h33, 1'b1, 5'd4, 32'h44, 1'b0, 5'd0);
    midCycle();
    checkOutput("rst_alu_ready", 64'(alu_ready), 64'd0);
    checkOutput("rst_lsu_ready", 64'(lsu_ready), 64'd0);
    stepClock();
    checkOutput("rst_no_we", 64'(WriteEnable), 64'd0);

    // Single ALU request right after reset.
    applyStimulus(1'b0, 1'b1, 5'd5, 32'hDEADBEEF, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0);
    midCycle();
    checkOutput("single_alu_ready", 64'(alu_ready), 64'd1);
    checkOutput("single_lsu_ready", 64'(lsu_ready), 64'd0);
    stepClock();
    checkOutput("single_we", 64'(WriteEnable), 64'd1);
    checkOutput("single_ws", 64'(WriteSelect), 64'd5);
    checkOutput("single_wd", 64'(WriteData), 64'hDEADBEEF);
    idle(1'b0);
    stepClock();
    checkOutput("idle_we_drop", 64'(WriteEnable), 64'd0);
    checkOutput("idle_ws_hold", 64'(WriteSelect), 64'd5);
    checkOutput("idle_wd_hold", 64'(WriteData), 64'hDEADBEEF);

    // Fresh reset, then four contested cycles alternate ALU, LSU, ALU, LSU.
    idle(1'b1);
    stepClock();
    applyStimulus(1'b0, 1'b1, 5'd1, 32'hA1, 1'b1, 5'd2, 32'hB2, 1'b0, 5'd0);
    for (int k = 0; k < 4; k++) begin
      midCycle();
      checkOutput($sformatf("rr_alu_ready%0d", k), 64'(alu_ready), (k % 2 == 0) ? 64'd1 : 64'd0);
      checkOutput($sformatf("rr_lsu_ready%0d", k), 64'(lsu_ready), (k % 2 == 0) ? 64'd0 : 64'd1);
      stepClock();
      checkOutput($sformatf("rr_we%0d", k), 64'(WriteEnable), 64'd1);
      checkOutput($sformatf("rr_ws%0d", k), 64'(WriteSelect), (k % 2 == 0) ? 64'd1 : 64'd2);
      checkOutput($sformatf("rr_wd%0d", k), 64'(WriteData), (k % 2 == 0) ? 64'hA1 : 64'hB2);
    end
    idle(1'b0);
    stepClock();
    checkOutput("rr_end_we", 64'(WriteEnable), 64'd0);

    // Scoreboard set by issue, cleared by a later LSU writeback.
    applyStimulus(1'b0, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 1'b1, 5'd7);
    stepClock();
    checkOutput("sb7_set", 64'(busy), 64'h80);
    idle(1'b0);
    stepClock();
    stepClock();
    applyStimulus(1'b0, 1'b0, 5'd0, 32'h0, 1'b1, 5'd7, 32'h77, 1'b0, 5'd0);
    midCycle();
    checkOutput("sb7_lsu_ready", 64'(lsu_ready), 64'd1);
    stepClock();
    checkOutput("sb7_we", 64'(WriteEnable), 64'd1);
    checkOutput("sb7_ws", 64'(WriteSelect), 64'd7);
    checkOutput("sb7_busy_still", 64'(busy), 64'h80);
    idle(1'b0);
    stepClock();
    checkOutput("sb7_cleared", 64'(busy), 64'h0);

    // Set wins over clear of the same register.
    applyStimulus(1'b0, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 1'b1, 5'd9);
    stepClock();
    checkOutput("sb9_set", 64'(busy), 64'h200);
    applyStimulus(1'b0, 1'b0, 5'd0, 32'h0, 1'b1, 5'd9, 32'h99, 1'b0, 5'd0);
    stepClock();
    checkOutput("sb9_we", 64'(WriteEnable), 64'd1);
    applyStimulus(1'b0, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 1'b1, 5'd9);
    stepClock();
    checkOutput("sb9_set_wins", 64'(busy), 64'h200);

    // Clear of one register and set of another in the same cycle.
    applyStimulus(1'b0, 1'b0, 5'd0, 32'h0, 1'b1, 5'd9, 32'h99, 1'b0, 5'd0);
    stepClock();
    applyStimulus(1'b0, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 1'b1, 5'd4);
    stepClock();
    checkOutput("sb_set4_clr9", 64'(busy), 64'h10);

    // Writes and issues to r0.
    applyStimulus(1'b0, 1'b1, 5'd0, 32'h1, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0);
    midCycle();
    checkOutput("r0_alu_ready", 64'(alu_ready), 64'd1);
    stepClock();
    checkOutput("r0_we", 64'(WriteEnable), 64'd0);
    applyStimulus(1'b0, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 1'b1, 5'd0);
    stepClock();
    checkOutput("r0_issue_busy", 64'(busy), 64'h10);

    // Clear r4, then clear it again while it is already idle.
    applyStimulus(1'b0, 1'b0, 5'd0, 32'h0, 1'b1, 5'd4, 32'h44, 1'b0, 5'd0);
    stepClock();
    applyStimulus(1'b0, 1'b0, 5'd0, 32'h0, 1'b1, 5'd4, 32'h45, 1'b0, 5'd0);
    stepClock();
    checkOutput("clr4_busy", 64'(busy), 64'h0);
    idle(1'b0);
    stepClock();
    checkOutput("clr4_again_busy", 64'(busy), 64'h0);

    // ALU transfer then reset: the captured write never appears, and the
    // pointer is back to favouring the ALU even though the ALU won last.
    applyStimulus(1'b0, 1'b1, 5'd6, 32'h66, 1'b0, 5'd0, 32'h0, 1'b1, 5'd8);
    midCycle();
    checkOutput("pre_rst_alu_ready", 64'(alu_ready), 64'd1);
    stepClock();
    idle(1'b1);
    midCycle();
    checkOutput("rst_mask_we", 64'(WriteEnable), 64'd0);
    stepClock();
    idle(1'b0);
    checkOutput("post_rst_we", 64'(WriteEnable), 64'd0);
    checkOutput("post_rst_busy", 64'(busy), 64'h0);
    checkOutput("post_rst_ws", 64'(WriteSelect), 64'd0);
    applyStimulus(1'b0, 1'b1, 5'd10, 32'hAA, 1'b1, 5'd11, 32'hBB, 1'b0, 5'd0);
    midCycle();
    checkOutput("post_rst_alu_wins", 64'(alu_ready), 64'd1);
    checkOutput("post_rst_lsu_waits", 64'(lsu_ready), 64'd0);
    stepClock();
    checkOutput("post_rst_ws_alu", 64'(WriteSelect), 64'd10);
    checkOutput("post_rst_wd_alu", 64'(WriteData), 64'hAA);
    idle(1'b0);
    stepClock();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
